// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg
//   Shared types and helpers for the memory-stage data-bus sequencer.
//   mem_size_t    : access width (BYTE, HALF, WORD)
//   mctrl_state_t : sequencer states (IDLE, REQ, DONE)
//   BUS_STRB_W    : number of byte-lane strobes on the data bus
//   Helpers compute lane strobes, store-data replication, forced-aligned
//   offsets and misalignment detection for a given width and low address bits.
package mem_access_ctrl_pkg;

    localparam int unsigned BUS_STRB_W = 4;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        DONE = 2'b10
    } mctrl_state_t;

    // Low address bits with the bits that the access width ignores cleared.
    function automatic logic [1:0] aligned_off(input mem_size_t size, input logic [1:0] off);
        case (size)
            BYTE:    aligned_off = off;
            HALF:    aligned_off = {off[1], 1'b0};
            default: aligned_off = 2'b00;
        endcase
    endfunction

    function automatic logic misaligned_off(input mem_size_t size, input logic [1:0] off);
        case (size)
            BYTE:    misaligned_off = 1'b0;
            HALF:    misaligned_off = off[0];
            default: misaligned_off = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [BUS_STRB_W-1:0] lane_strb(input mem_size_t size, input logic [1:0] off);
        case (size)
            BYTE:    lane_strb = 4'b0001 << off;
            HALF:    lane_strb = 4'b0011 << {off[1], 1'b0};
            default: lane_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input mem_size_t size, input logic [31:0] d);
        case (size)
            BYTE:    lane_data = {4{d[7:0]}};
            HALF:    lane_data = {2{d[15:0]}};
            default: lane_data = d;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_ctrl_load_align.sv
// mem_load_align
//   Combinational load alignment: moves the addressed byte/half of the bus
//   word down to bit 0 and sign- or zero-extends it.
//   rdata     in  32  raw bus read data
//   offset    in  2   byte offset within the word (half uses offset[1] only)
//   size      in      access width
//   ld_signed in  1   1 = sign-extend, 0 = zero-extend
//   data      out 32  aligned, extended result
module mem_load_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  mem_size_t   size,
    input  logic        ld_signed,
    output logic [31:0] data
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    always_comb begin
        byte_sh = rdata >> {offset, 3'b000};
        half_sh = rdata >> {offset[1], 4'b0000};
        case (size)
            BYTE:    data = {{24{ld_signed & byte_sh[7]}}, byte_sh[7:0]};
            HALF:    data = {{16{ld_signed & half_sh[15]}}, half_sh[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Memory-stage data-bus sequencer: one req/ready bus transaction per
//   load/store, with pipeline stall, load alignment and a bus timeout.
//   Optional macro MISALIGN_TRAP_EN: misaligned accesses trap (misaligned
//   pulse, no bus request) instead of being forced to natural alignment.
//   Parameter BUS_TIMEOUT: REQ wait cycles before bus_err (0 = disabled).
//   Ports:
//     clk, rst            clock (rising), async active-high reset
//     flush               squash the instruction in the memory stage
//     dread, dwrite       load request / store size (00 none,01 b,10 h,11 w)
//     ld_size, ld_signed  load width (00 b,01 h,10 w) and extension
//     addr, wdata         byte address and LSB-justified store data
//     stall               hold upstream pipeline latches
//     load_data/valid     aligned load result and its 1-cycle valid
//     bus_err, misaligned 1-cycle fault pulses
//     bus_req/wen/addr/wstrb/wdata, bus_rdata, bus_ready  data bus
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  dread,
    input  logic [1:0]            dwrite,
    input  logic [1:0]            ld_size,
    input  logic                  ld_signed,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  stall,
    output logic [31:0]           load_data,
    output logic                  load_valid,
    output logic                  bus_err,
    output logic                  misaligned,
    output logic                  bus_req,
    output logic                  bus_wen,
    output logic [31:0]           bus_addr,
    output logic [BUS_STRB_W-1:0] bus_wstrb,
    output logic [31:0]           bus_wdata,
    input  logic [31:0]           bus_rdata,
    input  logic                  bus_ready
);

    localparam int unsigned CNT_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT + 1);

    mctrl_state_t state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]  off_q;
    mem_size_t   size_q;
    logic        sign_q;
    logic        flushed_q;
    logic        lv_q;
    logic [31:0] aligned_data;

    logic        is_store;
    logic        access;
    logic        trap;
    logic        start;
    logic        ready_eff;
    mem_size_t   st_size;
    mem_size_t   ld_sz;
    mem_size_t   acc_size;
    logic [1:0]  acc_off;

    always_comb begin
        is_store = (dwrite != 2'b00);
        access   = (dread | is_store) & ~flush;
        case (dwrite)
            2'b01:   st_size = BYTE;
            2'b10:   st_size = HALF;
            default: st_size = WORD;
        endcase
        case (ld_size)
            2'b00:   ld_sz = BYTE;
            2'b01:   ld_sz = HALF;
            default: ld_sz = WORD;
        endcase
        acc_size = is_store ? st_size : ld_sz;
        acc_off  = aligned_off(acc_size, addr[1:0]);
    end

`ifdef MISALIGN_TRAP_EN
    assign trap = misaligned_off(acc_size, addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    assign start     = (state == IDLE) & access & ~trap;
    // bus_ready is only meaningful while the request is actually raised.
    assign ready_eff = bus_req & bus_ready;

    // A flushed access releases the pipeline in the ready cycle itself
    // because it skips DONE; rst gating keeps stall low during reset even
    // though the stage inputs are still presenting the old access.
    assign stall      = ~rst & (start | ((state == REQ) & ~(ready_eff & (flushed_q | flush))));
    assign misaligned = ~rst & (state == IDLE) & access & trap;
    assign load_valid = lv_q & ~flush;

    mem_load_align u_align (
        .rdata     (bus_rdata),
        .offset    (off_q),
        .size      (size_q),
        .ld_signed (sign_q),
        .data      (aligned_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            off_q     <= '0;
            size_q    <= BYTE;
            sign_q    <= 1'b0;
            flushed_q <= 1'b0;
            lv_q      <= 1'b0;
            load_data <= '0;
            bus_err   <= 1'b0;
            bus_req   <= 1'b0;
            bus_wen   <= 1'b0;
            bus_addr  <= '0;
            bus_wstrb <= '0;
            bus_wdata <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bus_req   <= 1'b1;
                        bus_wen   <= is_store;
                        bus_addr  <= {addr[31:2], 2'b00};
                        bus_wstrb <= is_store ? lane_strb(acc_size, acc_off) : '0;
                        bus_wdata <= is_store ? lane_data(st_size, wdata) : '0;
                        off_q     <= acc_off;
                        size_q    <= acc_size;
                        sign_q    <= ld_signed;
                        flushed_q <= 1'b0;
                        cnt       <= '0;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (flush) begin
                        flushed_q <= 1'b1;
                    end
                    if (ready_eff) begin
                        bus_req <= 1'b0;
                        cnt     <= '0;
                        if (flushed_q | flush) begin
                            state <= IDLE;
                        end else begin
                            state <= DONE;
                            lv_q  <= ~bus_wen;
                            if (!bus_wen) begin
                                load_data <= aligned_data;
                            end
                        end
                    end else if (!bus_req) begin
                        // Timeout cycle (bus_err high): retire without a result.
                        cnt   <= '0;
                        lv_q  <= 1'b0;
                        state <= DONE;
                    end else if (BUS_TIMEOUT != 0) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(BUS_TIMEOUT - 1)) begin
                            bus_err <= 1'b1;
                            bus_req <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    lv_q  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
//   Directed bench for mem_access_ctrl (BUS_TIMEOUT overridden to 4).
//   Honors MISALIGN_TRAP_EN for the misaligned-address scenarios.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        dread;
    logic [1:0]  dwrite;
    logic [1:0]  ld_size;
    logic        ld_signed;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        bus_err;
    logic        misaligned;
    logic        bus_req;
    logic        bus_wen;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wstrb;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ready;

    int checks = 0;
    int errors = 0;
    int nstall;

    logic        snap_req;
    logic        snap_wen;
    logic [31:0] snap_addr;
    logic [3:0]  snap_strb;
    logic [31:0] snap_wdata;

    mem_access_ctrl #(.BUS_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .dread      (dread),
        .dwrite     (dwrite),
        .ld_size    (ld_size),
        .ld_signed  (ld_signed),
        .addr       (addr),
        .wdata      (wdata),
        .stall      (stall),
        .load_data  (load_data),
        .load_valid (load_valid),
        .bus_err    (bus_err),
        .misaligned (misaligned),
        .bus_req    (bus_req),
        .bus_wen    (bus_wen),
        .bus_addr   (bus_addr),
        .bus_wstrb  (bus_wstrb),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_ready  (bus_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_idle();
        dread = 1'b0; dwrite = 2'b00; ld_size = 2'b00; ld_signed = 1'b0;
        addr = '0; wdata = '0; flush = 1'b0;
    endtask

    // Access inputs must already be applied in an IDLE cycle. Runs the bus
    // with 'waits' wait states, snapshots bus outputs in the ready cycle and
    // returns in the DONE cycle (after its falling edge).
    task automatic run_bus(input int waits, input logic [31:0] rd, output int ns);
        ns = 0;
        @(negedge clk); if (stall) ns++;
        for (int i = 0; i < waits; i++) begin
            tick();
            @(negedge clk); if (stall) ns++;
        end
        tick();
        bus_ready = 1'b1; bus_rdata = rd;
        @(negedge clk); if (stall) ns++;
        snap_req = bus_req; snap_wen = bus_wen; snap_addr = bus_addr;
        snap_strb = bus_wstrb; snap_wdata = bus_wdata;
        tick();
        bus_ready = 1'b0; bus_rdata = '0;
        @(negedge clk); if (stall) ns++;
    endtask

    initial begin
        rst = 1'b1; bus_ready = 1'b0; bus_rdata = '0;
        set_idle();
        repeat (2) @(posedge clk);
        #1;
        chk1 ("rst_stall", stall, 1'b0);
        chk1 ("rst_req", bus_req, 1'b0);
        chk32("rst_addr", bus_addr, 32'h0);
        chk32("rst_wdata", bus_wdata, 32'h0);
        chk32("rst_ldata", load_data, 32'h0);
        chk1 ("rst_lvalid", load_valid, 1'b0);
        chk1 ("rst_err", bus_err, 1'b0);
        chk1 ("rst_mis", misaligned, 1'b0);
        tick();
        rst = 1'b0;
        tick();

        // 1: sw to 0x1000_0006
        dwrite = 2'b11; addr = 32'h1000_0006; wdata = 32'hDEAD_BEEF;
`ifdef MISALIGN_TRAP_EN
        @(negedge clk);
        chk1("t1_mis", misaligned, 1'b1);
        chk1("t1_stall", stall, 1'b0);
        chk1("t1_req", bus_req, 1'b0);
        tick();
        set_idle();
        @(negedge clk);
        chk1("t1_req_after", bus_req, 1'b0);
        chk1("t1_mis_pulse", misaligned, 1'b0);
`else
        run_bus(0, 32'h0, nstall);
        chk1 ("t1_req", snap_req, 1'b1);
        chk1 ("t1_wen", snap_wen, 1'b1);
        chk32("t1_addr", snap_addr, 32'h1000_0004);
        chk32("t1_strb", {28'h0, snap_strb}, 32'hF);
        chk32("t1_wdata", snap_wdata, 32'hDEAD_BEEF);
        chk32("t1_nstall", 32'(nstall), 32'd2);
        chk1 ("t1_done_lv", load_valid, 1'b0);
        chk1 ("t1_done_req", bus_req, 1'b0);
        tick();
        set_idle();
`endif
        tick();

        // 2: lb signed / lbu at 0x2003
        dread = 1'b1; ld_size = 2'b00; ld_signed = 1'b1; addr = 32'h0000_2003;
        run_bus(0, 32'h8012_3456, nstall);
        chk32("t2_addr", snap_addr, 32'h0000_2000);
        chk32("t2_strb", {28'h0, snap_strb}, 32'h0);
        chk1 ("t2_wen", snap_wen, 1'b0);
        chk1 ("t2_lv", load_valid, 1'b1);
        chk32("t2_ldata", load_data, 32'hFFFF_FF80);
        chk1 ("t2_stall_done", stall, 1'b0);
        tick();
        ld_signed = 1'b0;
        @(negedge clk);
        chk1("t2_lv_pulse", load_valid, 1'b0);
        run_bus(0, 32'h8012_3456, nstall);
        chk32("t2u_ldata", load_data, 32'h0000_0080);
        chk1 ("t2u_lv", load_valid, 1'b1);

        // lh signed at 0x2002
        tick();
        ld_size = 2'b01; ld_signed = 1'b1; addr = 32'h0000_2002;
        run_bus(0, 32'h8001_0000, nstall);
        chk32("lh_ldata", load_data, 32'hFFFF_8001);
`ifndef MISALIGN_TRAP_EN
        // lhu at 0x2001: addr[0] ignored, low half selected
        tick();
        ld_signed = 1'b0; addr = 32'h0000_2001;
        run_bus(0, 32'h1234_8765, nstall);
        chk32("lhu_mis_ldata", load_data, 32'h0000_8765);
`endif
        tick();
        set_idle();
        tick();

        // 3: sh to 0x2002 with 3 wait states
        dwrite = 2'b10; addr = 32'h0000_2002; wdata = 32'h0000_1234;
        run_bus(3, 32'h0, nstall);
        chk32("t3_strb", {28'h0, snap_strb}, 32'hC);
        chk32("t3_wdata", snap_wdata, 32'h1234_1234);
        chk32("t3_nstall", 32'(nstall), 32'd5);
        tick();
        // sb to 0x2001
        dwrite = 2'b01; addr = 32'h0000_2001; wdata = 32'h0000_00A7;
        run_bus(0, 32'h0, nstall);
        chk32("sb_strb", {28'h0, snap_strb}, 32'h2);
        chk32("sb_wdata", snap_wdata, 32'hA7A7_A7A7);
        tick();
        set_idle();
        tick();

        // 4: lw flushed during REQ
        dread = 1'b1; ld_size = 2'b10; addr = 32'h0000_3000;
        tick();
        flush = 1'b1;
        @(negedge clk);
        chk1("t4_req", bus_req, 1'b1);
        chk1("t4_stall", stall, 1'b1);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk1("t4_req_held", bus_req, 1'b1);
        tick();
        bus_ready = 1'b1; bus_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk1("t4_stall_ready", stall, 1'b0);
        tick();
        bus_ready = 1'b0; bus_rdata = '0;
        set_idle();
        @(negedge clk);
        chk1("t4_lv", load_valid, 1'b0);
        chk1("t4_req_off", bus_req, 1'b0);
        chk1("t4_stall_idle", stall, 1'b0);
        tick();

        // 5: timeout after 4 REQ cycles
        dread = 1'b1; ld_size = 2'b10; addr = 32'h0000_4000;
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("t5_req_wait", bus_req, 1'b1);
            chk1("t5_err_wait", bus_err, 1'b0);
            tick();
        end
        @(negedge clk);
        chk1("t5_err", bus_err, 1'b1);
        chk1("t5_req_err", bus_req, 1'b0);
        chk1("t5_stall_err", stall, 1'b1);
        tick();
        @(negedge clk);
        chk1("t5_err_pulse", bus_err, 1'b0);
        chk1("t5_stall_done", stall, 1'b0);
        chk1("t5_lv", load_valid, 1'b0);
        tick();
        set_idle();
        dwrite = 2'b11; addr = 32'h0000_5000; wdata = 32'h1122_3344;
        run_bus(0, 32'h0, nstall);
        chk32("t5_next_strb", {28'h0, snap_strb}, 32'hF);
        chk32("t5_next_nstall", 32'(nstall), 32'd2);
        tick();
        set_idle();
        tick();

        // flush in DONE suppresses load_valid
        dread = 1'b1; ld_size = 2'b10; addr = 32'h0000_7000;
        run_bus(0, 32'hA5A5_A5A5, nstall);
        flush = 1'b1;
        #1;
        chk1("fd_lv_flush", load_valid, 1'b0);
        flush = 1'b0;
        #1;
        chk1 ("fd_lv_noflush", load_valid, 1'b1);
        chk32("fd_ldata", load_data, 32'hA5A5_A5A5);
        tick();
        set_idle();
        tick();

        // 6: async reset in REQ, then fresh lw
        dread = 1'b1; ld_size = 2'b10; addr = 32'h0000_6000;
        tick();
        @(negedge clk);
        chk1("t6_req", bus_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk1("t6_req_rst", bus_req, 1'b0);
        chk1("t6_stall_rst", stall, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        run_bus(1, 32'h55AA_1234, nstall);
        chk32("t6_ldata", load_data, 32'h55AA_1234);
        chk1 ("t6_lv", load_valid, 1'b1);
        chk32("t6_nstall", 32'(nstall), 32'd3);
        tick();
        set_idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
